alu_issue: RTL

- Sequencing front end that sits between decode/register-read and the 32-bit combinational ALU.
- Accepts one RISC-V ALU or branch request over a valid/ready handshake, then decodes it into the ALU's 4-bit alu_control and operand pair.
- Drives the ALU for one registered cycle and captures the returned result, zero and sign.
- Returns the result, branch decision and illegal flag over a second valid/ready handshake.

---
 rtl/alu_issue.sv | 102 ++++++++++
 1 files changed

// File: rtl/alu_issue.sv
// alu_issue: decodes one RISC-V ALU/branch request, drives an external ALU for a cycle and returns the response
module alu_issue #(
  parameter int REG_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [6:0]           req_opcode,
  input  logic [2:0]           req_funct3,
  input  logic                 req_funct7b5,
  input  logic [REG_WIDTH-1:0] req_rs1,
  input  logic [REG_WIDTH-1:0] req_rs2,
  input  logic [REG_WIDTH-1:0] req_imm,
  output logic [REG_WIDTH-1:0] alu_in1,
  output logic [REG_WIDTH-1:0] alu_in2,
  output logic [3:0]           alu_control,
  input  logic [REG_WIDTH-1:0] alu_result,
  input  logic                 alu_zero,
  input  logic                 alu_sign,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [REG_WIDTH-1:0] rsp_result,
  output logic                 rsp_taken,
  output logic                 rsp_illegal
);
  localparam int MSB = REG_WIDTH - 1;
  localparam logic [1:0] K_PLAIN = 2'd0, K_SLT = 2'd1, K_SLTU = 2'd2, K_BR = 2'd3;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_nx;
  logic is_r, is_i, is_b, ill, neg, shift;
  logic [REG_WIDTH-1:0] b, in2_nx;
  logic [3:0] ctrl_nx;
  logic [1:0] kind_nx, kind;
  logic [2:0] br_f3;
  logic ill_q, b_msb, a_msb, ovf, lt, ltu, taken;
  assign req_ready = state == IDLE;
  assign rsp_valid = state == RESP;
  // Decode the request into ALU control, operands and result kind; subtraction becomes ADD of the negated operand
  always_comb begin
    is_r = req_opcode == 7'b0110011;
    is_i = req_opcode == 7'b0010011;
    is_b = req_opcode == 7'b1100011;
    ill = !(is_r | is_i | is_b) | (is_b & req_funct3[2:1] == 2'b01);
    b = is_i ? req_imm : req_rs2;
    neg = is_b | req_funct3[2:1] == 2'b01 | (req_funct3 == 3'b000 & is_r & req_funct7b5);
    shift = req_funct3[1:0] == 2'b01;
    ctrl_nx = (ill | neg) ? 4'b0010 :
              req_funct3 == 3'b001 ? 4'b1000 :
              req_funct3 == 3'b101 ? {3'b101, req_funct7b5} :
              req_funct3 == 3'b100 ? 4'b0011 :
              req_funct3 == 3'b110 ? 4'b0001 :
              req_funct3 == 3'b111 ? 4'b0000 : 4'b0010;
    in2_nx = ill ? '0 : neg ? ~b + REG_WIDTH'(1) : shift ? {{(REG_WIDTH-5){1'b0}}, b[4:0]} : b;
    kind_nx = ill ? K_PLAIN : is_b ? K_BR : req_funct3 == 3'b010 ? K_SLT : req_funct3 == 3'b011 ? K_SLTU : K_PLAIN;
  end
  // Signed/unsigned compare and branch decision derived from the SUB result
  always_comb begin
    a_msb = alu_in1[MSB];
    ovf = (a_msb != b_msb) & (alu_result[MSB] != a_msb);
    lt = alu_sign ^ ovf;
    ltu = (a_msb != b_msb) ? b_msb : alu_sign;
    taken = br_f3[0] ^ (br_f3[2] ? (br_f3[1] ? ltu : lt) : alu_zero);
  end
  // State register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  // Next state: one EXEC cycle, then hold RESP until the consumer takes it
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (req_valid ? EXEC : IDLE) : state == EXEC ? RESP : (rsp_ready ? IDLE : RESP);
  end
  // Register the decoded request on accept, and the response at the end of EXEC
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      alu_in1 <= '0;
      alu_in2 <= '0;
      alu_control <= '0;
      kind <= K_PLAIN;
      br_f3 <= '0;
      ill_q <= 1'b0;
      b_msb <= 1'b0;
      rsp_result <= '0;
      rsp_taken <= 1'b0;
      rsp_illegal <= 1'b0;
    end else if (state == IDLE && req_valid) begin
      alu_in1 <= ill ? '0 : req_rs1;
      alu_in2 <= in2_nx;
      alu_control <= ctrl_nx;
      kind <= kind_nx;
      br_f3 <= req_funct3;
      ill_q <= ill;
      b_msb <= ill ? 1'b0 : b[MSB];
    end else if (state == EXEC) begin
      rsp_result <= ill_q ? '0 :
                    kind == K_SLT ? {{(REG_WIDTH-1){1'b0}}, lt} :
                    kind == K_SLTU ? {{(REG_WIDTH-1){1'b0}}, ltu} : alu_result;
      rsp_taken <= kind == K_BR & taken;
      rsp_illegal <= ill_q;
    end
endmodule
